// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner: 8-digit multiplexed hex display scanner with blanking, masking and zero suppression.
module seven_seg_scanner #(
  parameter int DIGIT_TICKS = 100000,
  parameter int BLANK_TICKS = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [31:0] value,
  input  logic [7:0]  dp,
  input  logic [7:0]  digit_en,
  input  logic        lz_en,
  output logic [7:0]  an_onehot,
  output logic [7:0]  an_n,
  output logic [6:0]  seg_n,
  output logic        dp_n,
  output logic        frame_start
);
  localparam int CW = $clog2(DIGIT_TICKS);
  logic [CW-1:0] cnt, cnt_nx;
  logic [2:0] pos, pos_nx;
  logic run, cap, tc, z, off, sup, lz_q, lz_nx;
  logic [31:0] val_q, val_nx;
  logic [7:0] dp_q, dp_nx, den_q, den_nx, zpre, oh;
  logic [3:0] nib;
  logic [6:0] seg;
  // Outputs are registered from the next state, so they describe the slot the edge enters.
  always_comb begin
    tc = cnt == CW'(DIGIT_TICKS - 1);
    cap = en && (!run || (tc && pos == 3'd7));
    cnt_nx = !en ? cnt : (tc || cap) ? '0 : cnt + CW'(1);
    pos_nx = !en ? pos : cap ? 3'd0 : tc ? pos + 3'd1 : pos;
    val_nx = cap ? value : val_q;
    dp_nx = cap ? dp : dp_q;
    den_nx = cap ? digit_en : den_q;
    lz_nx = cap ? lz_en : lz_q;
    nib = 4'(val_nx >> {~pos_nx, 2'b00});
    oh = 8'h80 >> pos_nx;
    z = 1'b1;
    zpre = '0;
    for (int i = 0; i < 8; i++) begin
      z = z && (val_nx[31-4*i -: 4] == 4'd0);
      zpre[i] = z;
    end
    off = !en || cnt_nx < CW'(BLANK_TICKS) || !den_nx[~pos_nx];
    sup = lz_nx && pos_nx != 3'd7 && zpre[pos_nx];
  end
  always_comb begin
    seg = 7'h7F;
    case (nib)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
    endcase
  end
  // A suppressed digit keeps its anode on only when its decimal point must show.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      pos <= '0;
      run <= 1'b0;
      val_q <= '0;
      dp_q <= '0;
      den_q <= '0;
      lz_q <= 1'b0;
      an_onehot <= 8'h80;
      an_n <= 8'hFF;
      seg_n <= 7'h7F;
      dp_n <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      cnt <= cnt_nx;
      pos <= pos_nx;
      run <= run | en;
      val_q <= val_nx;
      dp_q <= dp_nx;
      den_q <= den_nx;
      lz_q <= lz_nx;
      an_onehot <= oh;
      an_n <= (off || (sup && !dp_nx[~pos_nx])) ? 8'hFF : ~oh;
      seg_n <= (off || sup) ? 7'h7F : seg;
      dp_n <= off || !dp_nx[~pos_nx];
      frame_start <= cap;
    end
  end
endmodule

// File: tb/tb_seven_seg_scanner.sv
// tb_seven_seg_scanner: random and directed stimulus checked every cycle against an elapsed-count display model.
module tb_seven_seg_scanner;
  localparam int DT = 8;
  localparam int BT = 2;
  localparam logic [6:0] SEG [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  typedef struct packed {
    logic [7:0] oh;
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       fs;
  } out_t;

  logic clk = 0, rst_n = 0, en = 0, lz_en = 0;
  logic [31:0] value = 0;
  logic [7:0] dp = 0, digit_en = 0;
  logic [7:0] an_onehot, an_n;
  logic [6:0] seg_n;
  logic dp_n, frame_start;

  seven_seg_scanner #(.DIGIT_TICKS(DT), .BLANK_TICKS(BT)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .value(value), .dp(dp), .digit_en(digit_en),
    .lz_en(lz_en), .an_onehot(an_onehot), .an_n(an_n), .seg_n(seg_n), .dp_n(dp_n),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  int vec = 0, mis = 0;
  int e;
  logic [31:0] sv;
  logic [7:0] sdp, sden;
  logic slz;
  out_t ex;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      mis++;
      $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, exp);
    end
  endtask

  // n = enabled clock edges since reset; slot, position and frame follow by division.
  function automatic out_t model(int n, bit on, logic [31:0] v, logic [7:0] d, logic [7:0] m, bit lz);
    out_t r;
    int p, c;
    logic [3:0] nib;
    bit blank, sup;
    p = n == 0 ? 0 : ((n - 1) / DT) % 8;
    c = n == 0 ? 0 : (n - 1) % DT;
    r.oh = 8'h80 >> p;
    r.fs = on && n > 0 && (n - 1) % (8 * DT) == 0;
    nib = 4'(v >> (28 - 4 * p));
    blank = !on || c < BT || !m[7-p];
    sup = lz && p < 7 && (v >> (28 - 4 * p)) == 0;
    r.an = (blank || (sup && !d[7-p])) ? 8'hFF : ~r.oh;
    r.seg = (blank || sup) ? 7'h7F : SEG[nib];
    r.dp = blank || !d[7-p];
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e <= 0;
      sv <= '0;
      sdp <= '0;
      sden <= '0;
      slz <= 1'b0;
      ex <= model(0, 0, 0, 0, 0, 0);
    end else if (en) begin
      e <= e + 1;
      if (e % (8 * DT) == 0) begin
        sv <= value;
        sdp <= dp;
        sden <= digit_en;
        slz <= lz_en;
        ex <= model(e + 1, 1, value, dp, digit_en, lz_en);
      end else ex <= model(e + 1, 1, sv, sdp, sden, slz);
    end else ex <= model(e, 0, sv, sdp, sden, slz);
  end

  always @(negedge clk) begin
    chk("an_onehot", an_onehot, ex.oh);
    chk("an_n", an_n, ex.an);
    chk("seg_n", seg_n, ex.seg);
    chk("dp_n", dp_n, ex.dp);
    chk("frame_start", frame_start, ex.fs);
  end

  task automatic step(int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic align();
    int t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (frame_start !== 1'b1 && t < 300);
    chk("align_frame_start", frame_start, 1);
  endtask

  initial begin
    rst_n = 0; en = 0; value = 32'h0123ABCD; dp = 8'h01; digit_en = 8'hFF; lz_en = 0;
    step(3);
    chk("rst_oh", an_onehot, 8'h80);
    chk("rst_an", an_n, 8'hFF);
    chk("rst_seg", seg_n, 7'h7F);
    chk("rst_dp", dp_n, 1);
    chk("rst_fs", frame_start, 0);
    rst_n = 1; en = 1;
    @(negedge clk);
    chk("start_fs", frame_start, 1);
    chk("start_oh", an_onehot, 8'h80);
    chk("start_blank", an_n, 8'hFF);
    step(4);
    chk("d0_seg", seg_n, 7'h40);
    chk("d0_an", an_n, 8'h7F);
    chk("d0_dp", dp_n, 1);
    step(32);
    chk("d4_seg", seg_n, 7'h08);
    step(24);
    chk("d7_seg", seg_n, 7'h21);
    chk("d7_dp", dp_n, 0);
    for (int f = 0; f < 80; f++) begin
      step($urandom_range(1, 20));
      value = $urandom >> (4 * $urandom_range(0, 8));
      dp = 8'($urandom);
      digit_en = $urandom_range(0, 3) == 0 ? 8'($urandom) : 8'hFF;
      lz_en = 1'($urandom);
      en = $urandom_range(0, 4) != 0;
    end
    en = 1; value = 32'h50; lz_en = 1; dp = 0; digit_en = 8'hFF;
    align();
    step(4);
    chk("lz_d0_an", an_n, 8'hFF);
    step(40);
    chk("lz_d5_an", an_n, 8'hFF);
    step(8);
    chk("lz_d6_seg", seg_n, 7'h12);
    step(8);
    chk("lz_d7_seg", seg_n, 7'h40);
    value = 0;
    align();
    step(52);
    chk("lz0_d6_an", an_n, 8'hFF);
    step(8);
    chk("lz0_d7_seg", seg_n, 7'h40);
    chk("lz0_d7_an", an_n, 8'hFE);
    value = 32'h11111111; lz_en = 0;
    align();
    step(24);
    value = 32'h22222222;
    step(20);
    chk("tear_d5_seg", seg_n, 7'h79);
    align();
    step(4);
    chk("tear_next_seg", seg_n, 7'h24);
    digit_en = 8'hF0;
    align();
    step(44);
    chk("mask_d5_an", an_n, 8'hFF);
    digit_en = 8'hFF;
    align();
    step(43);
    en = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("hold_oh", an_onehot, 8'h04);
      chk("hold_an", an_n, 8'hFF);
      chk("hold_fs", frame_start, 0);
    end
    en = 1;
    step(70);
    @(posedge clk);
    #2 rst_n = 0;
    #1;
    chk("arst_oh", an_onehot, 8'h80);
    chk("arst_an", an_n, 8'hFF);
    chk("arst_seg", seg_n, 7'h7F);
    chk("arst_dp", dp_n, 1);
    chk("arst_fs", frame_start, 0);
    step(2);
    rst_n = 1;
    @(negedge clk);
    chk("rel_fs", frame_start, 1);
    chk("rel_oh", an_onehot, 8'h80);
    step(64);
    chk("rel_fs_period", frame_start, 1);
    $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
    $finish;
  end
endmodule

// File: doc/seven_seg_scanner.md
SEVEN_SEG_SCANNER -- requirements
Module: seven_seg_scanner

Interface
REQ-001 Parameters SHALL be, one per line:
- DIGIT_TICKS, default 100000, clk cycles per digit slot (>=4).
- BLANK_TICKS, default 1000, cycles at slot start with anodes off (< DIGIT_TICKS).
REQ-002 Ports SHALL be, one per line (clock and reset first):
- clk  in  1  system clock; sole clock.
- rst_n  in  1  reset; asynchronous, active-low.
- en  in  1  scan enable.
- value  in  32  eight hex nibbles; digit k shows value[31-4k -: 4], k=0 leftmost.
- dp  in  8  decimal points; dp[7-k] belongs to digit k.
- digit_en  in  8  digit mask; digit_en[7-k] belongs to digit k.
- lz_en  in  1  leading-zero suppression enable.
- an_onehot  out  8  active-high scan position; digit k = bit (7-k).
- an_n  out  8  active-low anode drive.
- seg_n  out  7  active-low segments {g,f,e,d,c,b,a}.
- dp_n  out  1  active-low decimal point.
- frame_start  out  1  one-cycle pulse when digit 0 slot begins.

Function
REQ-003 A slot counter SHALL count 0..DIGIT_TICKS-1 while en=1, wrapping to 0 and advancing the scan position at terminal count.
REQ-004 Scan position SHALL step digit 0,1,...,7 then wrap to 0; an_onehot SHALL rotate right: 1000_0000 -> 0100_0000 -> ... -> 0000_0001 -> 1000_0000.
REQ-005 an_onehot SHALL always be exactly one-hot, including while en=0.
REQ-006 On each entry into digit 0 (wrap from digit 7), value, dp, digit_en and lz_en SHALL be captured into shadow registers; displayed data SHALL change only at frame boundaries.
REQ-007 frame_start SHALL pulse for exactly the first cycle of each digit 0 slot, coincident with the shadow capture.
REQ-008 The digit displayed is blank if any of the following holds: its shadow digit_en bit is 0; the slot counter is < BLANK_TICKS; or en=0.
REQ-009 When the digit is blank, an_n SHALL be 8'hFF, seg_n 7'h7F, and dp_n 1.
REQ-010 Otherwise an_n SHALL be ~an_onehot.
REQ-011 Leading-zero suppression: with shadow lz_en=1, digit k (k<7) SHALL be blank when its nibble and every nibble of digits 0..k-1 are zero; digit 7 SHALL never be suppressed; dp_n SHALL still follow dp on a suppressed digit.
REQ-012 Hex decode (seg_n, gfedcba, hex), nibbles 0-7: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78.
REQ-013 Hex decode (seg_n, gfedcba, hex), nibbles 8-F: 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E.
REQ-014 an_onehot, an_n, seg_n, dp_n and frame_start SHALL all be registered and mutually cycle-aligned.
REQ-015 Output latency from a counter/position change to the outputs SHALL be exactly 1 clk.
REQ-016 en=0 SHALL freeze the slot counter and position, blank outputs per REQ-008 and suppress frame_start.
REQ-017 When en returns to 1, counting SHALL resume from the frozen count with no extra frame_start.
REQ-018 value changes mid-frame SHALL have no visible effect until the next frame_start.

Reset
REQ-019 Asynchronous assertion of rst_n=0 SHALL immediately force: slot counter 0; position digit 0; an_onehot 8'b1000_0000; an_n 8'hFF; seg_n 7'h7F; dp_n 1; frame_start 0.
REQ-020 Asynchronous assertion of rst_n=0 SHALL immediately clear all shadow registers to 0.
REQ-021 After release of rst_n, with en=1, the first clock edge SHALL begin the digit 0 slot, pulse frame_start and capture the shadows.
REQ-022 Reset mid-scan SHALL abandon the current slot with no partial-slot glitch on an_n.

Verification
REQ-023 Reset/startup (DIGIT_TICKS=8, BLANK_TICKS=2): drop rst_n mid-slot -> outputs take REQ-019 values without a clock; release with en=1 -> frame_start pulses once and an_onehot=1000_0000.
REQ-024 Scan order: en=1, digit_en=FF, 64+ cycles -> an_onehot rotates through all 8 positions, 8 cycles each; an_n=FF on first 2 cycles of each slot, then ~an_onehot; frame_start every 64 cycles.
REQ-025 Decode: value=0x0123ABCD, dp=8'h01, lz_en=0 -> digits 0..7 show seg_n 40,79,24,30,08,03,46,21; dp_n=0 only on digit 7.
REQ-026 Leading zeros: value=0x0000_0050, lz_en=1 -> digits 0-5 blank (an_n=FF), digit 6 shows 12, digit 7 shows 40; value=0 -> only digit 7 lit, showing 40.
REQ-027 Tearing/mask: change value from 0x11111111 to 0x22222222 during digit 3 -> digits 3-7 still show 79 that frame; next frame shows 24. digit_en=8'hF0 -> digits 4-7 never lit.
REQ-028 Enable: deassert en during digit 5 for 20 cycles -> an_n=FF, an_onehot holds 0000_0100, no frame_start; reassert -> slot completes remaining count.
